// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
// Segment patterns are active-low, packed {a,b,c,d,e,f,g} with a in the MSB.
package seven_seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        return HEX_SEG[value];
    endfunction

    // Counter width for a modulo-n counter, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seven_seg_scan_timer.sv
// Slot divider, digit index, frame counter and blink phase for the scan driver.
// frame_start is combinational so the snapshot and frame_tick can use the same edge.
module seven_seg_scan_timer
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_FRAMES = 250,
    localparam int DIV_W       = cnt_width(SCAN_DIV),
    localparam int IDX_W       = cnt_width(NUM_DIGITS),
    localparam int FRM_W       = cnt_width(BLINK_FRAMES)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [DIV_W-1:0] div_cnt,
    output logic [IDX_W-1:0] digit_idx,
    output logic             blink_phase,
    output logic             frame_start
);

    logic [FRM_W-1:0] frame_cnt;

    assign frame_start = (div_cnt == '0) && (digit_idx == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            digit_idx   <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
                div_cnt   <= '0;
                digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            // Blink phase flips once every BLINK_FRAMES frame starts.
            if (frame_start) begin
                if (frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + FRM_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with dead time,
// frame-coherent input snapshots, blanking, blinking and decimal points.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int DEAD_CYCLES  = 64,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [NUM_DIGITS-1:0]   blink,
    output logic [6:0]              segments,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   anode_active,
    output logic                    frame_tick
);

    localparam int DIV_W = cnt_width(SCAN_DIV);
    localparam int IDX_W = cnt_width(NUM_DIGITS);

    logic [DIV_W-1:0]        div_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic                    blink_phase;
    logic                    frame_start;

    logic [4*NUM_DIGITS-1:0] digits_s, digits_eff;
    logic [NUM_DIGITS-1:0]   dp_s, blank_s, blink_s;
    logic [NUM_DIGITS-1:0]   dp_eff, blank_eff, blink_eff;
    logic [3:0]              cur_digit;
    logic                    cur_dp, cur_blank, cur_blink;
    logic                    in_dead, dark;

    seven_seg_scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .SCAN_DIV    (SCAN_DIV),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .div_cnt    (div_cnt),
        .digit_idx  (digit_idx),
        .blink_phase(blink_phase),
        .frame_start(frame_start)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digits_s <= '0;
            dp_s     <= '0;
            blank_s  <= '0;
            blink_s  <= '0;
        end else if (frame_start) begin
            digits_s <= digits;
            dp_s     <= dp_in;
            blank_s  <= blank;
            blink_s  <= blink;
        end
    end

    // The frame-start cycle already belongs to the new frame, so it sees the
    // values being captured; this matters when dead time is disabled.
    assign digits_eff = frame_start ? digits : digits_s;
    assign dp_eff     = frame_start ? dp_in  : dp_s;
    assign blank_eff  = frame_start ? blank  : blank_s;
    assign blink_eff  = frame_start ? blink  : blink_s;

    always_comb begin
        cur_digit = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_blink = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                cur_digit = digits_eff[4*i +: 4];
                cur_dp    = dp_eff[i];
                cur_blank = blank_eff[i];
                cur_blink = blink_eff[i];
            end
        end
    end

    assign in_dead = int'(div_cnt) < DEAD_CYCLES;
    assign dark    = !enable || cur_blank || (cur_blink && blink_phase);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            anode_active <= '1;
            segments     <= SEG_OFF;
            dp_n         <= 1'b1;
            frame_tick   <= 1'b0;
        end else begin
            frame_tick <= frame_start;
            if (in_dead || dark) begin
                anode_active <= '1;
                segments     <= SEG_OFF;
                dp_n         <= 1'b1;
            end else begin
                anode_active <= ~(NUM_DIGITS'(1) << digit_idx);
                segments     <= hex_to_seg(cur_digit);
                dp_n         <= ~cur_dp;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboard bench: a cycle-count reference model queues expected outputs at each
// clock edge and the negedge checker pops and compares them against the DUT.
module tb_seven_seg_scan_driver;

    localparam int ND    = 4;
    localparam int SD    = 8;
    localparam int DC    = 2;
    localparam int BF    = 2;
    localparam int FRAME = SD * ND;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [15:0] digits;
    logic [3:0]  dp_in, blank, blink;
    logic [6:0]  segments;
    logic        dp_n;
    logic [3:0]  anode_active;
    logic        frame_tick;

    typedef struct packed {
        logic [3:0] anode;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
    } exp_t;

    exp_t        sbQueue[$];
    exp_t        popped;
    int          assertCount = 0;
    int          failCount   = 0;
    int          tcnt        = 0;
    logic [15:0] digitsS     = '0;
    logic [3:0]  dpS         = '0;
    logic [3:0]  blankS      = '0;
    logic [3:0]  blinkS      = '0;

    logic [6:0] segTable [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    always #5 clk = ~clk;

    seven_seg_scan_driver #(
        .NUM_DIGITS  (ND),
        .SCAN_DIV    (SD),
        .DEAD_CYCLES (DC),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .digits      (digits),
        .dp_in       (dp_in),
        .blank       (blank),
        .blink       (blink),
        .segments    (segments),
        .dp_n        (dp_n),
        .anode_active(anode_active),
        .frame_tick  (frame_tick)
    );

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Expected outputs after the coming edge, derived from cycles since reset release.
    function automatic exp_t expectedNow();
        exp_t        e;
        int          div, slot, frameIdx;
        logic [15:0] d;
        logic [3:0]  p, bl, bk;
        logic        phase;
        e.anode = 4'hF;
        e.seg   = 7'h7F;
        e.dp    = 1'b1;
        e.tick  = 1'b0;
        if (!rst_n) return e;
        div      = tcnt % SD;
        slot     = (tcnt / SD) % ND;
        frameIdx = tcnt / FRAME;
        e.tick   = (tcnt % FRAME) == 0;
        if ((tcnt % FRAME) == 0) begin
            d = digits; p = dp_in; bl = blank; bk = blink;
        end else begin
            d = digitsS; p = dpS; bl = blankS; bk = blinkS;
        end
        phase = (((frameIdx + 1) / BF) % 2) == 1;
        if (div >= DC && enable && !bl[slot] && !(bk[slot] && phase)) begin
            e.anode       = 4'hF;
            e.anode[slot] = 1'b0;
            e.seg         = segTable[d[4*slot +: 4]];
            e.dp          = ~p[slot];
        end
        return e;
    endfunction

    always @(posedge clk) begin
        sbQueue.push_back(expectedNow());
        if (!rst_n) begin
            tcnt    <= 0;
            digitsS <= '0;
            dpS     <= '0;
            blankS  <= '0;
            blinkS  <= '0;
        end else begin
            tcnt <= tcnt + 1;
            if ((tcnt % FRAME) == 0) begin
                digitsS <= digits;
                dpS     <= dp_in;
                blankS  <= blank;
                blinkS  <= blink;
            end
        end
    end

    always @(negedge clk) begin
        if (sbQueue.size() > 0) begin
            popped = sbQueue.pop_front();
            checkOutput("anode", 16'(anode_active), 16'(popped.anode));
            checkOutput("segments", 16'(segments), 16'(popped.seg));
            checkOutput("dp_n", 16'(dp_n), 16'(popped.dp));
            checkOutput("frame_tick", 16'(frame_tick), 16'(popped.tick));
            checkOutput("one_anode", 16'($countones(~anode_active) <= 1), 16'd1);
        end
    end

    task automatic applyStimulus(input logic r, input logic en, input logic [15:0] d,
                                 input logic [3:0] p, input logic [3:0] bl, input logic [3:0] bk,
                                 input int cycles);
        rst_n  = r;
        enable = en;
        digits = d;
        dp_in  = p;
        blank  = bl;
        blink  = bk;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        $display("[TB] reset and scan");
        applyStimulus(1'b0, 1'b1, 16'h1234, 4'h0, 4'h0, 4'h0, 3);
        applyStimulus(1'b1, 1'b1, 16'h1234, 4'h0, 4'h0, 4'h0, 12);

        $display("[TB] coherent snapshot");
        applyStimulus(1'b1, 1'b1, 16'hABCD, 4'h0, 4'h0, 4'h0, 52);

        $display("[TB] blank and blink");
        applyStimulus(1'b1, 1'b1, 16'h9E07, 4'h0, 4'b0010, 4'b0001, 5 * FRAME);

        $display("[TB] decimal point");
        applyStimulus(1'b1, 1'b1, 16'h4F68, 4'b0100, 4'h0, 4'h0, 2 * FRAME);

        $display("[TB] enable off mid-frame");
        applyStimulus(1'b1, 1'b1, 16'h1C5B, 4'b1001, 4'h0, 4'h0, 20);
        applyStimulus(1'b1, 1'b0, 16'h1C5B, 4'b1001, 4'h0, 4'h0, 50);
        applyStimulus(1'b1, 1'b1, 16'h1C5B, 4'b1001, 4'h0, 4'h0, 40);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 2 * FRAME && (tcnt % FRAME) != 2 * SD + 5; i++) @(negedge clk);
        if ((tcnt % FRAME) != 2 * SD + 5)
            checkOutput("reset_align_wait", 16'(tcnt % FRAME), 16'(2 * SD + 5));
        applyStimulus(1'b0, 1'b1, 16'h5678, 4'b0010, 4'h0, 4'h0, 2);
        applyStimulus(1'b1, 1'b1, 16'h5678, 4'b0010, 4'h0, 4'h0, 40);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
